// File: rtl/tdm_pkg.sv
// Shared definitions for the four-channel TDM demultiplexer: FSM encoding,
// channel/select widths and the bit-counter width helper.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : tdm_pkg

// File: rtl/tdm_demux4_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer. The stream source
// uses the master view, the demultiplexer the slave view.
interface tdm_demux4_if #(
  parameter int WIDTH = 4
);

  logic             din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic             frame_valid;
  logic             sync_err;
  logic             locked;
  logic [1:0]       sel;

  modport master (
    output din, din_valid, frame_sync,
    input  y0, y1, y2, y3, frame_valid, sync_err, locked, sel
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y0, y1, y2, y3, frame_valid, sync_err, locked, sel
  );

endinterface : tdm_demux4_if

// File: rtl/tdm_slot_shifter.sv
// MSB-first slot shift register with its bit counter. word_done_o flags that
// a shift on this cycle delivers the last bit, and word_o is then the full word.
module tdm_slot_shifter
  import tdm_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_done_o,
  output logic [CNT_W-1:0] bitcnt_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;

  assign word_o      = {shift_q[WIDTH-2:0], din_i};
  assign word_done_o = (bitcnt_q == LAST);
  assign bitcnt_o    = bitcnt_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through this block can leave it unassigned and infer a latch.
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (load_i) begin
      shift_d  = {{(WIDTH-1){1'b0}}, din_i};
      bitcnt_d = ONE;
    end else if (shift_i) begin
      shift_d  = word_o;
      bitcnt_d = word_done_o ? '0 : bitcnt_q + ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
    end
  end

endmodule : tdm_slot_shifter

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: frame-sync FSM, slot select, staging of
// slots 0..2 and the registered parallel outputs with framing-error reporting.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] stage_q [NUM_CH-1];
  logic [WIDTH-1:0] stage_d [NUM_CH-1];
  logic [WIDTH-1:0] y_q [NUM_CH];
  logic [WIDTH-1:0] y_d [NUM_CH];
  logic             fv_q, fv_d;
  logic             err_q, err_d;

  logic             load, shift;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic [CNT_W-1:0] bitcnt;
  logic             boundary;

  tdm_slot_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .shift_i     (shift),
    .din_i       (bus.din),
    .word_o      (word),
    .word_done_o (word_done),
    .bitcnt_o    (bitcnt)
  );

  // Next beat in RECV is expected to be channel 0 MSB carrying frame_sync.
  assign boundary = (sel_q == '0) && (bitcnt == '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    stage_d = stage_q;
    y_d     = y_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (bus.din_valid && bus.frame_sync) begin
          load    = 1'b1;
          sel_d   = '0;
          state_d = RECV;
        end
      end

      RECV: begin
        if (bus.din_valid) begin
          if (boundary && !bus.frame_sync) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (!boundary && bus.frame_sync) begin
            // Early sync: drop the partial frame and restart on this beat.
            err_d = 1'b1;
            load  = 1'b1;
            sel_d = '0;
          end else begin
            shift = 1'b1;
            if (word_done) begin
              sel_d = sel_q + SEL_W'(1);
              if (sel_q == LAST_SEL) begin
                y_d[0] = stage_q[0];
                y_d[1] = stage_q[1];
                y_d[2] = stage_q[2];
                y_d[3] = word;
                fv_d   = 1'b1;
              end else begin
                stage_d[sel_q] = word;
              end
            end
          end
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sel_q   <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      // NOTE: staging and output words are plain flops, not a RAM, so they
      // can and must clear on reset: y0..y3 read zero until a full frame.
      for (int i = 0; i < NUM_CH - 1; i++) stage_q[i] <= '0;
      for (int i = 0; i < NUM_CH; i++)     y_q[i]     <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      stage_q <= stage_d;
      y_q     <= y_d;
    end
  end

  assign bus.y0          = y_q[0];
  assign bus.y1          = y_q[1];
  assign bus.y2          = y_q[2];
  assign bus.y3          = y_q[3];
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = err_q;
  assign bus.locked      = (state_q == RECV);
  assign bus.sel         = sel_q;

endmodule : tdm_demux4

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Four-channel time-division demultiplexer. It receives a serial, slot-interleaved stream and returns each slot to its own parallel channel output. Each frame carries four slots (channel 0..3) of WIDTH bits, MSB first, and a frame-sync marker flags the first bit of channel 0. The block sits at the receiving end of the channel-select path and recovers the four channel words into registered outputs, with a per-frame valid strobe.

Parameters:
WIDTH, 4, bits per slot (channel word width), legal range 2..16
NUM_CH, 4, channels per frame; fixed at 4, not overridable

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  1  serial data bit
din_valid  input  1  qualifies din and frame_sync; a cycle with din_valid=1 is a "beat"
frame_sync  input  1  high on the beat carrying channel 0, bit WIDTH-1; ignored when din_valid=0
y0  output  WIDTH  channel 0 word of last complete frame
y1  output  WIDTH  channel 1 word
y2  output  WIDTH  channel 2 word
y3  output  WIDTH  channel 3 word
frame_valid  output  1  one-cycle pulse coincident with new y0..y3 values
sync_err  output  1  one-cycle pulse on a framing error
locked  output  1  high while in RECV
sel  output  2  slot currently being received (s1,s0 order: sel[1]=s1)

Behaviour:
- Reset (rst_n=0, asynchronous): state=HUNT; bit counter=0; sel=0; shift and staging regs=0; y0..y3=0; frame_valid=0; sync_err=0; locked=0. Release is synchronous to clk; the first beat is accepted on the first rising edge after release.
- All outputs are registered. frame_valid and sync_err default to 0 each cycle. Cycles with din_valid=0 are stalls, with no state or counter change.
- HUNT:
  - Beats with frame_sync=0 are discarded.
  - A beat with frame_sync=1 loads din as slot 0 MSB and sets bitcnt=1 and sel=0. Next state is RECV and locked goes to 1.
- RECV, on each beat:
  - din shifts into the shift reg LSB (MSB-first arrival); bitcnt increments.
  - When bitcnt==WIDTH-1 (last bit of slot), the completed word is written to staging[sel]; bitcnt becomes 0 and sel increments modulo 4.
  - When sel==3 completes: y0..y2 are loaded from staging 0..2 and y3 from the completed word, all on the same edge. frame_valid=1 for exactly that following cycle. sel wraps to 0.
- Sync checking in RECV:
  - At the frame-boundary beat (sel==0, bitcnt==0), frame_sync must be 1. If it is 0, sync_err pulses, the state returns to HUNT, locked=0, and the beat is discarded.
  - frame_sync=1 on any other RECV beat is an early sync. sync_err pulses and the partial frame is discarded (y unchanged, no frame_valid). The beat is then treated as slot 0 MSB: bitcnt=1, sel=0, state stays RECV.
- Latency: y0..y3 and frame_valid update on the rising edge that samples the 4*WIDTH-th beat of the frame.
- Back-to-back frames need no idle beat. A correct sync on the boundary beat continues reception seamlessly.
- Reset mid-frame: everything clears immediately and the partial frame is lost. y0..y3 read 0 until the next complete frame.
- A stalled frame never times out; reception resumes on the next beat.

Decomposition:
- Shared package/header tdm_pkg:
  - state encoding HUNT=1'b0, RECV=1'b1
  - NUM_CH=4, SEL_W=2
  - the bit-counter width function (clog2 of WIDTH)
- One sub-module, tdm_slot_shifter: WIDTH-bit MSB-first shift register plus bit counter, with load-first-bit, shift and word_done outputs.
- The top level holds the FSM, sel counter, staging registers, output registers and sync checks.

Test Plan:
- Reset check, WIDTH=4: assert rst_n=0 after 7 beats of a frame -> y0..y3=0, locked=0, sel=0, frame_valid=0 while low and after release.
- Clean frame: sync on beat 1, bit stream 1010_0101_1100_0011 on 16 consecutive beats -> y0=4'hA, y1=4'h5, y2=4'hC, y3=4'h3. frame_valid is high exactly one cycle, after the 16th beat edge, and sync_err never asserts.
- Stalls: same frame with din_valid=0 inserted after every beat -> identical y values; frame_valid occurs after the 16th valid beat (cycle 31), and sel holds during stalls.
- Back-to-back: two frames (A,5,C,3) then (1,2,3,4), sync on each boundary -> two frame_valid pulses 16 cycles apart, with y=1,2,3,4 after the second.
- Early sync: frame_sync=1 on beat 6, then a full 16-beat frame 0xF,0xE,0xD,0xC -> sync_err pulse on beat 6, no frame_valid for the aborted frame, then y=F,E,D,C.
- Missing sync: frame_sync=0 on beat 17 -> sync_err pulse, locked=0, state HUNT. Beats without sync are ignored, and a later sync frame decodes correctly.
